// File: rtl/demux_dispatch_pkg.sv
// demux_dispatch_pkg: shared types and helpers for the line-demux dispatch controller.
package demux_dispatch_pkg;

    typedef enum logic {IDLE, HOLD} dispatch_state_t;

    function automatic int line_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Supports up to 32 lines; callers truncate to DATA_LINES.
    function automatic logic [31:0] onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/demux_credit_counter.sv
// demux_credit_counter: per-line credit counter, saturating at CREDITS with an overflow pulse.
module demux_credit_counter #(
    parameter int CREDITS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    output logic nonzero,
    output logic overflow
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        overflow = inc && !dec && cnt_q == FULL;
        cnt_d    = (dec && !inc) ? cnt_q - 1'b1 :
                   (inc && !dec && !overflow) ? cnt_q + 1'b1 : cnt_q;
        nonzero  = |cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= FULL;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: single-slot, credit-gated dispatcher driving a one-hot line demux.
// Define DEMUX_DISPATCH_STATS_EN to add saturating per-line dispatch counters (dispatch_count).
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_LINES = 4,
    parameter int CREDITS    = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [line_w(DATA_LINES)-1:0]  in_line,
    output logic                           out_valid,
    output logic [DATA_LINES-1:0]          out_sel,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic [DATA_LINES-1:0]          out_ready,
    input  logic [DATA_LINES-1:0]          credit_return,
    output logic [DATA_LINES-1:0]          credit_avail,
    output logic                           err
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    output logic [DATA_LINES*STAT_WIDTH-1:0] dispatch_count
`endif
);

    localparam int LW = line_w(DATA_LINES);

    dispatch_state_t       state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]         line_q, line_d;
    logic                  err_q, err_d;
    logic [DATA_LINES-1:0] sel, dec, ovf;
    logic                  accept, line_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        accept  = in_valid && in_ready;
        line_ok = {1'b0, in_line} < (LW + 1)'(DATA_LINES);
        state_d = state_q;
        data_d  = data_q;
        line_d  = line_q;
        if (accept && line_ok) begin
            state_d = HOLD;
            data_d  = in_data;
            line_d  = in_line;
        end else if (state_q == HOLD && |dec) begin
            state_d = IDLE;
        end
        err_d = err_q || (accept && !line_ok) || |ovf;
    end

    // Readiness in HOLD comes from the transfer itself, giving one word per cycle.
    always_comb begin
        sel       = DATA_LINES'(onehot(int'(line_q)));
        out_valid = state_q == HOLD && |(sel & credit_avail);
        out_sel   = out_valid ? sel : '0;
        dec       = out_sel & out_ready;
        in_ready  = !reset && (state_q == IDLE || |dec);
        out_data  = data_q;
        err       = err_q;
    end

    for (genvar i = 0; i < DATA_LINES; i++) begin : g_line
        demux_credit_counter #(.CREDITS(CREDITS)) u_credit (
            .clk      (clk),
            .reset    (reset),
            .dec      (dec[i]),
            .inc      (credit_return[i]),
            .nonzero  (credit_avail[i]),
            .overflow (ovf[i])
        );
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    for (genvar i = 0; i < DATA_LINES; i++) begin : g_stat
        logic [STAT_WIDTH-1:0] cnt_q, cnt_d;
        always_comb cnt_d = (dec[i] && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        always_ff @(posedge clk) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end
        assign dispatch_count[i*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_demux_dispatch_ctrl;

    localparam int CR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, err;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_line;
    logic [3:0]  out_sel, out_ready, credit_return, credit_avail;

    logic        in_valid3, in_ready3, out_valid3, err3;
    logic [1:0]  in_line3;
    logic [2:0]  out_sel3, out_ready3, credit_return3, credit_avail3;
    logic [31:0] out_data3;

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [63:0] dispatch_count;
    logic [47:0] dispatch_count3;
`endif

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.DATA_WIDTH(32), .DATA_LINES(4), .CREDITS(CR), .STAT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_line(in_line), .out_valid(out_valid), .out_sel(out_sel), .out_data(out_data),
        .out_ready(out_ready), .credit_return(credit_return), .credit_avail(credit_avail), .err(err)
`ifdef DEMUX_DISPATCH_STATS_EN
        , .dispatch_count(dispatch_count)
`endif
    );

    demux_dispatch_ctrl #(.DATA_WIDTH(32), .DATA_LINES(3), .CREDITS(CR), .STAT_WIDTH(16)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
        .in_line(in_line3), .out_valid(out_valid3), .out_sel(out_sel3), .out_data(out_data3),
        .out_ready(out_ready3), .credit_return(credit_return3), .credit_avail(credit_avail3), .err(err3)
`ifdef DEMUX_DISPATCH_STATS_EN
        , .dispatch_count(dispatch_count3)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: one optional held word plus a credit balance per line.
    bit          m_held;
    logic [31:0] m_data;
    int          m_line;
    int          m_cred[4];
    bit          m_err;
    int          m_cnt[4];

    function automatic void m_reset();
        m_held = 0; m_data = '0; m_line = 0; m_err = 0;
        for (int i = 0; i < 4; i++) begin
            m_cred[i] = CR;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic logic m_ov();
        return m_held && m_cred[m_line] > 0;
    endfunction

    function automatic logic [3:0] m_sel();
        return m_ov() ? 4'(1 << m_line) : 4'b0;
    endfunction

    function automatic logic m_ir();
        return m_held ? (m_ov() && out_ready[m_line]) : 1'b1;
    endfunction

    function automatic logic [3:0] m_avail();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = m_cred[i] > 0;
        return a;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] d, input logic [1:0] l,
                         input logic [3:0] ordy, input logic [3:0] cr);
        in_valid = iv; in_data = d; in_line = l; out_ready = ordy; credit_return = cr;
        #1;
    endtask

    task automatic tick();
        logic xf, acc, dc, ic;
        xf  = m_ov() && out_ready[m_line];
        acc = in_valid && m_ir();
        for (int i = 0; i < 4; i++) begin
            dc = xf && m_line == i;
            ic = credit_return[i];
            if (dc && !ic) m_cred[i]--;
            else if (ic && !dc) begin
                if (m_cred[i] == CR) m_err = 1;
                else m_cred[i]++;
            end
            if (dc && m_cnt[i] != 65535) m_cnt[i]++;
        end
        if (acc) begin
            m_held = 1; m_data = in_data; m_line = int'(in_line);
        end else if (xf) m_held = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, '0, '0);
        in_valid3 = 0; in_line3 = '0; out_ready3 = '0; credit_return3 = '0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        m_reset();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 32'h1234_5678, 2'd1, 4'hf, '0);
        reset = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        else n_pass++;
        in_valid = 0;
        @(posedge clk);
        #1;
        reset = 0;
        m_reset();
        #1;
        n_total++;
        if ({in_ready, out_valid, out_sel, out_data, err, credit_avail} !== {1'b1, 1'b0, 4'b0, 32'b0, 1'b0, 4'hf})
            $display("FAIL reset_state: got rdy=%b ov=%b sel=%b data=%h err=%b avail=%b want 1 0 0000 00000000 0 1111",
                     in_ready, out_valid, out_sel, out_data, err, credit_avail);
        else n_pass++;
`ifdef DEMUX_DISPATCH_STATS_EN
        n_total++;
        if (dispatch_count !== '0) $display("FAIL reset_stats: got %h want 0", dispatch_count);
        else n_pass++;
`endif
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 32'hA5A5_A5A5, 2'd2, 4'b0100, '0);
        tick();
        drive(0, '0, '0, 4'b0100, '0);
        n_total++;
        if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 4'b0100, 32'hA5A5_A5A5, 1'b1})
            $display("FAIL single_offer: got ov=%b sel=%b data=%h rdy=%b want 1 0100 a5a5a5a5 1",
                     out_valid, out_sel, out_data, in_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({out_valid, out_sel, credit_avail} !== {1'b0, 4'b0, 4'b1111})
            $display("FAIL single_after: got ov=%b sel=%b avail=%b want 0 0000 1111", out_valid, out_sel, credit_avail);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 32'h1111_0000, 2'd1, 4'hf, '0);
        tick();
        drive(1, 32'h1111_0001, 2'd1, 4'hf, '0);
        n_total++;
        if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 4'b0010, 32'h1111_0000, 1'b1})
            $display("FAIL b2b_first: got ov=%b sel=%b data=%h rdy=%b want 1 0010 11110000 1", out_valid, out_sel, out_data, in_ready);
        else n_pass++;
        tick();
        drive(1, 32'h1111_0002, 2'd1, 4'hf, '0);
        n_total++;
        if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 4'b0010, 32'h1111_0001, 1'b1})
            $display("FAIL b2b_second: got ov=%b sel=%b data=%h rdy=%b want 1 0010 11110001 1", out_valid, out_sel, out_data, in_ready);
        else n_pass++;
        tick();
        drive(0, '0, '0, 4'hf, '0);
        n_total++;
        if ({out_valid, in_ready, credit_avail, out_sel, out_data} !== {1'b0, 1'b0, 4'b1101, 4'b0, 32'h1111_0002})
            $display("FAIL b2b_starved: got ov=%b rdy=%b avail=%b sel=%b data=%h want 0 0 1101 0000 11110002",
                     out_valid, in_ready, credit_avail, out_sel, out_data);
        else n_pass++;
        drive(0, '0, '0, 4'hf, 4'b0010);
        tick();
        drive(0, '0, '0, 4'hf, '0);
        n_total++;
        if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 4'b0010, 32'h1111_0002, 1'b1})
            $display("FAIL b2b_resume: got ov=%b sel=%b data=%h rdy=%b want 1 0010 11110002 1", out_valid, out_sel, out_data, in_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({out_valid, credit_avail, err} !== {1'b0, 4'b1101, 1'b0})
            $display("FAIL b2b_drained: got ov=%b avail=%b err=%b want 0 1101 0", out_valid, credit_avail, err);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 32'hCAFE_0003, 2'd3, 4'b0111, '0);
        tick();
        drive(1, 32'hBEEF_0000, 2'd0, 4'b0111, '0);
        for (int c = 0; c < 5; c++) begin
            n_total++;
            if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 4'b1000, 32'hCAFE_0003, 1'b0})
                $display("FAIL stall_hold[%0d]: got ov=%b sel=%b data=%h rdy=%b want 1 1000 cafe0003 0",
                         c, out_valid, out_sel, out_data, in_ready);
            else n_pass++;
            tick();
        end
        drive(1, 32'hBEEF_0000, 2'd0, 4'b1000, '0);
        n_total++;
        if ({in_ready, out_sel} !== {1'b1, 4'b1000})
            $display("FAIL stall_release: got rdy=%b sel=%b want 1 1000", in_ready, out_sel);
        else n_pass++;
        tick();
        n_total++;
        if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 4'b0001, 32'hBEEF_0000, 1'b0})
            $display("FAIL stall_next: got ov=%b sel=%b data=%h rdy=%b want 1 0001 beef0000 0", out_valid, out_sel, out_data, in_ready);
        else n_pass++;
    endtask

    task automatic test_bad_line();
        do_reset();
        in_valid3 = 1; in_line3 = 2'd3; in_data = 32'hDEAD_0003;
        #1;
        n_total++;
        if ({in_ready3, err3} !== {1'b1, 1'b0})
            $display("FAIL bad_line_pre: got rdy=%b err=%b want 1 0", in_ready3, err3);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid3 = 0;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({err3, out_valid3, out_sel3, in_ready3} !== {1'b1, 1'b0, 3'b000, 1'b1})
                $display("FAIL bad_line_drop[%0d]: got err=%b ov=%b sel=%b rdy=%b want 1 0 000 1", c, err3, out_valid3, out_sel3, in_ready3);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        in_valid3 = 1; in_line3 = 2'd2; in_data = 32'h0000_0302;
        @(posedge clk);
        #1;
        in_valid3 = 0;
        n_total++;
        if ({err3, out_valid3, out_sel3, out_data3} !== {1'b1, 1'b1, 3'b100, 32'h0000_0302})
            $display("FAIL bad_line_recover: got err=%b ov=%b sel=%b data=%h want 1 1 100 00000302", err3, out_valid3, out_sel3, out_data3);
        else n_pass++;
        in_data = '0;
    endtask

    task automatic test_credit_err();
        do_reset();
        drive(0, '0, '0, '0, 4'b0001);
        n_total++;
        if (err !== 1'b0) $display("FAIL credit_err_pre: got %b want 0", err);
        else n_pass++;
        tick();
        drive(1, 32'hC0DE_0000, 2'd0, 4'b0001, '0);
        n_total++;
        if ({err, credit_avail} !== {1'b1, 4'b1111})
            $display("FAIL credit_overflow: got err=%b avail=%b want 1 1111", err, credit_avail);
        else n_pass++;
        tick();
        drive(1, 32'hC0DE_0001, 2'd0, 4'b0001, 4'b0001);
        n_total++;
        if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 32'hC0DE_0000})
            $display("FAIL credit_same_cycle: got ov=%b rdy=%b data=%h want 1 1 c0de0000", out_valid, in_ready, out_data);
        else n_pass++;
        tick();
        drive(1, 32'hC0DE_0002, 2'd0, 4'b0001, '0);
        n_total++;
        if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 32'hC0DE_0001})
            $display("FAIL credit_second: got ov=%b rdy=%b data=%h want 1 1 c0de0001", out_valid, in_ready, out_data);
        else n_pass++;
        tick();
        drive(1, 32'hC0DE_0003, 2'd0, 4'b0001, '0);
        n_total++;
        if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 32'hC0DE_0002})
            $display("FAIL credit_third: got ov=%b rdy=%b data=%h want 1 1 c0de0002", out_valid, in_ready, out_data);
        else n_pass++;
        tick();
        drive(0, '0, '0, 4'b0001, '0);
        n_total++;
        if ({out_valid, in_ready, out_data, credit_avail, err} !== {1'b0, 1'b0, 32'hC0DE_0003, 4'b1110, 1'b1})
            $display("FAIL credit_exhausted: got ov=%b rdy=%b data=%h avail=%b err=%b want 0 0 c0de0003 1110 1",
                     out_valid, in_ready, out_data, credit_avail, err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        drive(1, 32'h5EED_0000, 2'd2, 4'b0100, 4'b1000);
        tick();
        drive(1, 32'h5EED_0001, 2'd2, 4'b0100, '0);
        tick();
        drive(1, 32'h5EED_0002, 2'd2, 4'b0100, '0);
        tick();
        drive(0, '0, '0, 4'b0100, '0);
        n_total++;
        if ({out_valid, err, credit_avail} !== {1'b0, 1'b1, 4'b1011})
            $display("FAIL mid_hold_pre: got ov=%b err=%b avail=%b want 0 1 1011", out_valid, err, credit_avail);
        else n_pass++;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        m_reset();
        #1;
        n_total++;
        if ({out_valid, out_sel, credit_avail, err, in_ready} !== {1'b0, 4'b0, 4'b1111, 1'b0, 1'b1})
            $display("FAIL mid_hold_reset: got ov=%b sel=%b avail=%b err=%b rdy=%b want 0 0000 1111 0 1",
                     out_valid, out_sel, credit_avail, err, in_ready);
        else n_pass++;
`ifdef DEMUX_DISPATCH_STATS_EN
        n_total++;
        if (dispatch_count !== '0) $display("FAIL mid_hold_stats: got %h want 0", dispatch_count);
        else n_pass++;
`endif
        tick();
        n_total++;
        if ({out_valid, out_sel} !== {1'b0, 4'b0})
            $display("FAIL mid_hold_quiet: got ov=%b sel=%b want 0 0000", out_valid, out_sel);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] cr;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) cr[i] = ($urandom_range(5) == 0);
            drive(1'($urandom), $urandom, 2'($urandom), 4'($urandom), cr);
            n_total++;
            if ({in_ready, out_valid, out_sel, out_data, credit_avail, err} !== {m_ir(), m_ov(), m_sel(), m_data, m_avail(), m_err})
                $display("FAIL random[%0d]: got rdy=%b ov=%b sel=%b data=%h avail=%b err=%b want %b %b %b %h %b %b",
                         c, in_ready, out_valid, out_sel, out_data, credit_avail, err,
                         m_ir(), m_ov(), m_sel(), m_data, m_avail(), m_err);
            else n_pass++;
            tick();
        end
`ifdef DEMUX_DISPATCH_STATS_EN
        n_total++;
        if (dispatch_count !== {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])})
            $display("FAIL random_stats: got %h want %h", dispatch_count,
                     {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
        else n_pass++;
`endif
    endtask

    initial begin
        reset = 1;
        in_valid3 = 0; in_line3 = '0; out_ready3 = '0; credit_return3 = '0;
        drive(0, '0, '0, '0, '0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_bad_line();
        test_credit_err();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
